// File: rtl/led_pattern_engine.sv
// Programmable LED pattern generator: rotate, bounce and Johnson modes
// advanced by a period timer, a step strobe or overridden by a parallel load.
module led_pattern_engine #(
  parameter int               WIDTH        = 8,
  parameter int               DIV_W        = 32,
  parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(5'b11111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             dir
);

  logic [DIV_W-1:0] counter;
  logic [DIV_W-1:0] last;
  logic             fire;
  logic             do_step;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic [WIDTH-1:0] nxt_leds;
  logic             nxt_dir;

  // period 0 behaves like 1, so the terminal count is 0 in both cases
  assign last    = (period == '0) ? '0 : period - DIV_W'(1);
  assign fire    = enable && (counter >= last);
  assign do_step = step || fire;

  assign rol = {leds[WIDTH-2:0], leds[WIDTH-1]};
  assign ror = {leds[0], leds[WIDTH-1:1]};

  always_comb begin
    nxt_leds = leds;
    nxt_dir  = dir;
    unique case (mode)
      2'b00: nxt_leds = rol;
      2'b01: nxt_leds = ror;
      2'b10: begin
        if (!dir) begin
          if (leds[WIDTH-1]) begin
            nxt_dir  = 1'b1;
            nxt_leds = ror;
          end else begin
            nxt_leds = rol;
          end
        end else begin
          if (leds[0]) begin
            nxt_dir  = 1'b0;
            nxt_leds = rol;
          end else begin
            nxt_leds = ror;
          end
        end
      end
      2'b11: nxt_leds = {leds[WIDTH-2:0], ~leds[WIDTH-1]};
      default: nxt_leds = leds;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds    <= INIT_PATTERN;
      counter <= '0;
      dir     <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      leds    <= load_value;
      counter <= '0;
      dir     <= 1'b0;
      tick    <= 1'b0;
    end else if (do_step) begin
      leds    <= nxt_leds;
      dir     <= nxt_dir;
      counter <= '0;
      tick    <= 1'b1;
    end else begin
      tick <= 1'b0;
      if (enable) counter <= counter + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: directed scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_led_pattern_engine;

  localparam int W  = 8;
  localparam int DW = 32;
  localparam logic [W-1:0] INIT = 8'h1F;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] period;
  logic          load;
  logic [W-1:0]  load_value;
  logic          step;
  logic [W-1:0]  leds;
  logic          tick;
  logic          dir;

  led_pattern_engine #(.WIDTH(W), .DIV_W(DW), .INIT_PATTERN(INIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
    .load(load), .load_value(load_value), .step(step),
    .leds(leds), .tick(tick), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pat;
    bit          tk;
    bit          dr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // reference state: pattern as an integer, elapsed enabled cycles
  int unsigned m_pat;
  bit          m_dir;
  longint      m_elapsed;

  localparam int unsigned MASK = (1 << W) - 1;

  function automatic int unsigned apply_step(int unsigned p, int md,
                                             bit d, output bit nd);
    int unsigned msb, lsb, left, right;
    msb   = (p >> (W - 1)) & 1;
    lsb   = p & 1;
    left  = ((p * 2) & MASK) | msb;
    right = (p / 2) | (lsb << (W - 1));
    nd    = d;
    case (md)
      0: return left;
      1: return right;
      2: begin
        if (d == 0 && msb == 1) begin nd = 1; return right; end
        if (d == 1 && lsb == 1) begin nd = 0; return left; end
        return d ? right : left;
      end
      default: return ((p * 2) & MASK) | (1 - msb);
    endcase
  endfunction

  task automatic model_cycle();
    exp_t   e;
    longint eff;
    bit     nd;
    e.tk = 0;
    if (rst) begin
      m_pat = INIT; m_dir = 0; m_elapsed = 0;
    end else if (load) begin
      m_pat = load_value; m_dir = 0; m_elapsed = 0;
    end else begin
      eff = (period == 0) ? 1 : longint'(period);
      if (step || (enable && (m_elapsed + 1 >= eff))) begin
        m_pat = apply_step(m_pat, int'(mode), m_dir, nd);
        m_dir = nd;
        m_elapsed = 0;
        e.tk = 1;
      end else if (enable) begin
        m_elapsed++;
      end
    end
    e.pat = m_pat;
    e.dr  = m_dir;
    q.push_back(e);
  endtask

  task automatic cyc_drive(input logic r, input logic en, input logic [1:0] m,
                           input logic [DW-1:0] p, input logic l,
                           input logic [W-1:0] lv, input logic s);
    @(negedge clk);
    rst = r; enable = en; mode = m; period = p;
    load = l; load_value = lv; step = s;
    model_cycle();
  endtask

  task automatic run(input int n, input logic [1:0] m, input logic [DW-1:0] p);
    for (int i = 0; i < n; i++) cyc_drive(0, 1, m, p, 0, '0, 0);
  endtask

  // monitor: one expected response per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if (leds !== W'(e.pat) || tick !== e.tk || dir !== e.dr) begin
          n_fail++;
          $display("FAIL cyc%0d leds/tick/dir got %h/%b/%b expected %h/%b/%b",
                   cyc, leds, tick, dir, W'(e.pat), e.tk, e.dr);
        end
      end
    end
  end

  initial begin
    rst = 1; enable = 0; mode = 0; period = 4;
    load = 0; load_value = 0; step = 0;
    m_pat = INIT; m_dir = 0; m_elapsed = 0;

    // reset, then rotate left every 4th clock
    cyc_drive(1, 0, 2'b00, 4, 0, '0, 0);
    cyc_drive(1, 0, 2'b00, 4, 0, '0, 0);
    run(20, 2'b00, 4);
    // bounce from a single bit
    cyc_drive(0, 1, 2'b10, 1, 1, 8'h01, 0);
    run(30, 2'b10, 1);
    // Johnson fill from zero, full 16-step cycle and a bit more
    cyc_drive(0, 1, 2'b11, 1, 1, 8'h00, 0);
    run(20, 2'b11, 1);
    // paused single steps, then load colliding with step
    cyc_drive(0, 0, 2'b00, 3, 0, '0, 0);
    cyc_drive(0, 0, 2'b00, 3, 0, '0, 1);
    cyc_drive(0, 0, 2'b00, 3, 0, '0, 0);
    cyc_drive(0, 0, 2'b00, 3, 0, '0, 1);
    cyc_drive(0, 0, 2'b00, 3, 0, '0, 0);
    cyc_drive(0, 0, 2'b01, 3, 1, 8'hA5, 1);
    cyc_drive(0, 0, 2'b01, 3, 0, '0, 0);
    // period 0, then shrink a long period under the running count
    run(5, 2'b01, 0);
    run(51, 2'b00, 100);
    run(4, 2'b00, 3);
    // asynchronous reset between clock edges
    @(negedge clk);
    enable = 1; mode = 2'b00; period = 2; load = 0; step = 0;
    #2 rst = 1;
    #1;
    n_checks++;
    if (leds !== INIT || tick !== 1'b0 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst leds/tick/dir got %h/%b/%b expected %h/0/0",
               leds, tick, dir, INIT);
    end
    model_cycle();
    run(6, 2'b00, 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc_drive($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) < 8,
                2'($urandom_range(0, 3)),
                DW'($urandom_range(0, 6)),
                $urandom_range(0, 19) == 0,
                W'($urandom),
                $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    rst = 0; load = 0; step = 0; enable = 0;
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
